// File: rtl/bus_pair_loader_pkg.sv
// Shared definitions for the serial nibble-pair loader.
// State encoding and default nibble width.
package bus_pair_loader_pkg;

  localparam int NIBBLE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT_A = 2'd1,
    SHIFT_B = 2'd2,
    HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/bus_pair_loader_if.sv
// Control, serial and pair-output bundle of the loader.
// slave = loader side, master = feeder/consumer side.
interface bus_pair_loader_if
  import bus_pair_loader_pkg::*;
#(
  parameter int NIBBLE_W = NIBBLE_W_DEF
);

  logic                start;
  logic                ser_in;
  logic                ser_valid;
  logic                out_ready;
  logic                out_valid;
  logic                busy;
  logic [NIBBLE_W-1:0] out_1;
  logic [NIBBLE_W-1:0] out_2;

  modport master (
    output start,
    output ser_in,
    output ser_valid,
    output out_ready,
    input  out_valid,
    input  busy,
    input  out_1,
    input  out_2
  );

  modport slave (
    input  start,
    input  ser_in,
    input  ser_valid,
    input  out_ready,
    output out_valid,
    output busy,
    output out_1,
    output out_2
  );

endinterface

// File: rtl/bus_pair_loader_nibble_shift_reg.sv
// Left-shifting nibble register, new bit enters the LSB.
// clr wins over en.
module nibble_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] q
);

  // shift one bit in per enabled cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q << 1) | W'(bit_in);
    end
  end

endmodule

// File: rtl/bus_pair_loader.sv
// Assembles two MSB-first serial nibbles (A then B)
// and presents them as a valid/ready pair.
module bus_pair_loader
  import bus_pair_loader_pkg::*;
#(
  parameter int NIBBLE_W = NIBBLE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  bus_pair_loader_if.slave  bus
);

  localparam int CW = $clog2(NIBBLE_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLE_W - 1);

  state_e              state;
  state_e              state_n;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_n;
  logic                sh_a;
  logic                sh_b;
  logic                load;
  logic [NIBBLE_W-1:0] a_q;
  logic [NIBBLE_W-1:0] b_q;
  logic [NIBBLE_W-1:0] b_nxt;
  logic [NIBBLE_W-1:0] out_1;
  logic [NIBBLE_W-1:0] out_2;

  nibble_shift_reg #(.W(NIBBLE_W)) u_a (
    .clk    (clk),
    .clr    (rst),
    .en     (sh_a),
    .bit_in (bus.ser_in),
    .q      (a_q)
  );

  nibble_shift_reg #(.W(NIBBLE_W)) u_b (
    .clk    (clk),
    .clr    (rst),
    .en     (sh_b),
    .bit_in (bus.ser_in),
    .q      (b_q)
  );

  // B's final bit is still in flight on the load edge
  assign b_nxt = (b_q << 1) | NIBBLE_W'(bus.ser_in);

  // next state, counter and shift enables
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_a    = 1'b0;
    sh_b    = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = SHIFT_A;
          cnt_n   = '0;
        end
      end
      SHIFT_A: begin
        if (bus.ser_valid) begin
          sh_a = 1'b1;
          if (cnt == LAST) begin
            state_n = SHIFT_B;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      SHIFT_B: begin
        if (bus.ser_valid) begin
          sh_b = 1'b1;
          if (cnt == LAST) begin
            state_n = HOLD;
            cnt_n   = '0;
            load    = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_n = bus.start ? SHIFT_A : IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // state, counter and output pair registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      out_1 <= '0;
      out_2 <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        out_1 <= a_q;
        out_2 <= b_nxt;
      end
    end
  end

  assign bus.out_1     = out_1;
  assign bus.out_2     = out_2;
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state == SHIFT_A) ||
                         (state == SHIFT_B);

endmodule

// File: tb/tb_bus_pair_loader.sv
// Randomised self-checking bench for bus_pair_loader.
// Expected pair is the serial stream split MSB-first.
module tb_bus_pair_loader;
  import bus_pair_loader_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cnt_max = 0;

  always #5 clk = ~clk;

  bus_pair_loader_if #(.NIBBLE_W(N)) bus ();

  bus_pair_loader #(.NIBBLE_W(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk)
    if (int'(dut.cnt) > cnt_max) cnt_max = int'(dut.cnt);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    bus.start     = 1'b1;
    bus.ser_valid = 1'b1;
    bus.ser_in    = 1'($urandom);
    step;
    bus.start     = 1'b0;
    bus.ser_valid = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: toggle 1/0, else random
  task automatic stream(input logic [2*N-1:0] bits,
                        input int from, input int nbits,
                        input int mode, input logic st,
                        output int cycles);
    int   idx;
    int   sent;
    logic v;
    idx = from;
    sent = 0;
    cycles = 0;
    bus.start = st;
    while (sent < nbits) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.ser_valid = v;
      bus.ser_in = v ? bits[idx] : 1'($urandom);
      step;
      cycles++;
      if (v) begin
        idx--;
        sent++;
      end
      if (cycles > 200) begin
        checks++;
        failures++;
        $display("FAIL stream_timeout got=%0d bits req=%0d",
                 sent, nbits);
        break;
      end
    end
    bus.ser_valid = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.ser_valid = 1'b1;
    bus.ser_in = 1'b1;
    bus.out_ready = 1'b1;
    step;
    step;
    bus.start = 1'b0;
    bus.ser_valid = 1'b0;
    checks++;
    if (bus.out_1 !== 4'b0 || bus.out_2 !== 4'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b/%b req=0000/0000",
               bus.out_1, bus.out_2);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b req=00",
               bus.out_valid, bus.busy);
    end
    rst = 1'b0;
    step;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy got=%b req=0", bus.busy);
    end
  endtask

  task automatic test_basic;
    logic [7:0] p;
    int c;
    p = 8'b0001_1000;
    bus.out_ready = 1'b1;
    do_start;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b req=1", bus.busy);
    end
    stream(p, 7, 7, 0, 1'b0, c);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early got=%b req=0", bus.out_valid);
    end
    stream(p, 0, 1, 0, 1'b0, c);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_1 !== 4'b0001 ||
        bus.out_2 !== 4'b1000) begin
      failures++;
      $display("FAIL basic_pair got=%b %b/%b req=1 0001/1000",
               bus.out_valid, bus.out_1, bus.out_2);
    end
    step;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_1 !== 4'b0001 || bus.out_2 !== 4'b1000) begin
      failures++;
      $display("FAIL basic_idle got=%b%b %b/%b req=00 0001/1000",
               bus.out_valid, bus.busy, bus.out_1, bus.out_2);
    end
  endtask

  task automatic test_stall;
    int c;
    bus.out_ready = 1'b1;
    do_start;
    stream(8'b0001_1000, 7, 8, 1, 1'b0, c);
    checks++;
    if (c !== 15) begin
      failures++;
      $display("FAIL stall_cycles got=%0d req=15", c);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_1 !== 4'b0001 ||
        bus.out_2 !== 4'b1000) begin
      failures++;
      $display("FAIL stall_pair got=%b %b/%b req=1 0001/1000",
               bus.out_valid, bus.out_1, bus.out_2);
    end
    step;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_xfer got=%b req=0", bus.out_valid);
    end
  endtask

  task automatic test_hold;
    int c;
    bus.out_ready = 1'b0;
    do_start;
    stream(8'b0011_1100, 7, 8, 0, 1'b0, c);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_1 !== 4'b0011 ||
          bus.out_2 !== 4'b1100) begin
        failures++;
        $display("FAIL hold_%0d got=%b %b/%b req=1 0011/1100",
                 i, bus.out_valid, bus.out_1, bus.out_2);
      end
      step;
    end
    bus.out_ready = 1'b1;
    step;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_1 !== 4'b0011 ||
        bus.out_2 !== 4'b1100) begin
      failures++;
      $display("FAIL hold_xfer got=%b %b/%b req=0 0011/1100",
               bus.out_valid, bus.out_1, bus.out_2);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    int c;
    r = 8'($urandom);
    bus.out_ready = 1'b0;
    do_start;
    stream(r, 7, 8, 2, 1'b0, c);
    checks++;
    if (bus.out_1 !== r[7:4] || bus.out_2 !== r[3:0]) begin
      failures++;
      $display("FAIL b2b_first got=%b/%b req=%b/%b",
               bus.out_1, bus.out_2, r[7:4], r[3:0]);
    end
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_1 !== r[7:4] || bus.out_2 !== r[3:0]) begin
      failures++;
      $display("FAIL b2b_enter got=%b%b %b/%b req=10 %b/%b",
               bus.busy, bus.out_valid, bus.out_1, bus.out_2,
               r[7:4], r[3:0]);
    end
    stream(8'b0111_1110, 7, 8, 0, 1'b0, c);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_1 !== 4'b0111 ||
        bus.out_2 !== 4'b1110) begin
      failures++;
      $display("FAIL b2b_second got=%b %b/%b req=1 0111/1110",
               bus.out_valid, bus.out_1, bus.out_2);
    end
    bus.out_ready = 1'b1;
    step;
  endtask

  task automatic test_abort;
    logic [7:0] r;
    int c;
    r = 8'($urandom);
    bus.out_ready = 1'b0;
    do_start;
    stream(r, 7, 6, 2, 1'b0, c);
    rst = 1'b1;
    bus.ser_valid = 1'b1;
    step;
    rst = 1'b0;
    bus.ser_valid = 1'b0;
    checks++;
    if (bus.out_1 !== 4'b0 || bus.out_2 !== 4'b0 ||
        bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_clear got=%b%b %b/%b req=00 0000/0000",
               bus.out_valid, bus.busy, bus.out_1, bus.out_2);
    end
    do_start;
    stream(8'hFF, 7, 8, 0, 1'b0, c);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_1 !== 4'b1111 ||
        bus.out_2 !== 4'b1111) begin
      failures++;
      $display("FAIL abort_reload got=%b %b/%b req=1 1111/1111",
               bus.out_valid, bus.out_1, bus.out_2);
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step;
    rst = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.out_1 !== 4'b0 || bus.out_2 !== 4'b0 ||
        bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_hold got=%b%b %b/%b req=00 0000/0000",
               bus.out_valid, bus.busy, bus.out_1, bus.out_2);
    end
  endtask

  task automatic test_start_ignored;
    logic [7:0] r;
    int c;
    r = 8'($urandom);
    bus.out_ready = 1'b0;
    do_start;
    stream(r, 7, 4, 2, 1'b1, c);
    stream(r, 3, 4, 2, 1'b1, c);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_1 !== r[7:4] ||
        bus.out_2 !== r[3:0]) begin
      failures++;
      $display("FAIL start_ign got=%b %b/%b req=1 %b/%b",
               bus.out_valid, bus.out_1, bus.out_2,
               r[7:4], r[3:0]);
    end
    bus.out_ready = 1'b1;
    step;
    checks++;
    if (cnt_max > N - 1) begin
      failures++;
      $display("FAIL cnt_bound got=%0d req<=%0d", cnt_max, N - 1);
    end
  endtask

  task automatic test_random;
    logic [7:0] r;
    logic       pend;
    int         c;
    int         h;
    pend = 1'b0;
    for (int i = 0; i < 30; i++) begin
      r = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!pend) do_start;
      stream(r, 7, 8, 2, 1'b0, c);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_1 !== r[7:4] ||
          bus.out_2 !== r[3:0]) begin
        failures++;
        $display("FAIL rand_%0d got=%b %b/%b req=1 %b/%b", i,
                 bus.out_valid, bus.out_1, bus.out_2,
                 r[7:4], r[3:0]);
      end
      bus.out_ready = 1'b0;
      h = $urandom_range(0, 3);
      for (int k = 0; k < h; k++) step;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_1 !== r[7:4] ||
          bus.out_2 !== r[3:0]) begin
        failures++;
        $display("FAIL rand_hold_%0d got=%b %b/%b req=1 %b/%b", i,
                 bus.out_valid, bus.out_1, bus.out_2,
                 r[7:4], r[3:0]);
      end
      pend = 1'($urandom_range(0, 1));
      bus.out_ready = 1'b1;
      bus.start = pend;
      step;
      bus.start = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== pend) begin
        failures++;
        $display("FAIL rand_xfer_%0d got=%b%b req=0%b", i,
                 bus.out_valid, bus.busy, pend);
      end
    end
    if (pend) begin
      rst = 1'b1;
      step;
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ser_in = 1'b0;
    bus.ser_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_stall;
    test_hold;
    test_back_to_back;
    test_abort;
    test_start_ignored;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_pair_loader.md
BUS_PAIR_LOADER -- requirements
Module: bus_pair_loader

Interface
REQ-001 Parameter NIBBLE_W, default 4: width of each assembled nibble; this SHALL match the bus_breakout input width.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  begins a new load when sampled high in IDLE, or in HOLD together with a transfer.
REQ-005 ser_in  input  1  serial data bit, MSB first; nibble A is sent first, then nibble B.
REQ-006 ser_valid  input  1  qualifies ser_in; a bit is accepted only on a cycle where ser_valid=1 in SHIFT_A or SHIFT_B.
REQ-007 out_1  output  NIBBLE_W  assembled nibble A; drives bus_breakout in_1.
REQ-008 out_2  output  NIBBLE_W  assembled nibble B; drives bus_breakout in_2.
REQ-009 out_valid  output  1  high while out_1 and out_2 hold a completed, untransferred pair.
REQ-010 out_ready  input  1  downstream accept; a transfer occurs on a cycle where out_valid=1 and out_ready=1.
REQ-011 busy  output  1  high in SHIFT_A and SHIFT_B.

Function
REQ-012 The FSM SHALL have four states: IDLE, SHIFT_A, SHIFT_B and HOLD.
REQ-013 IDLE: start=1 -> SHIFT_A, with the bit counter cleared to 0; all other inputs SHALL be ignored.
REQ-014 SHIFT_A: each accepted bit SHALL shift left into the A shift register (new bit enters the LSB) and increment the counter; the NIBBLE_W-th accepted bit -> SHIFT_B, with the counter cleared.
REQ-015 SHIFT_B: SHALL behave identically using the B shift register; the NIBBLE_W-th accepted bit -> HOLD.
REQ-016 ser_valid=0 in SHIFT_A or SHIFT_B SHALL stall the FSM with no state, counter or register change.
REQ-017 On the cycle of entry to HOLD, out_1 and out_2 SHALL load the A and B shift registers; outside that cycle out_1 and out_2 SHALL keep their value, including after the transfer.
REQ-018 out_valid SHALL rise on the clock edge that accepts the final B bit, so it is visible in the following cycle (latency 1 cycle after the last bit).
REQ-019 HOLD with out_ready=0: the FSM SHALL stay in HOLD; out_valid, out_1 and out_2 SHALL stay stable.
REQ-020 HOLD with out_ready=1 and start=0: -> IDLE, with out_valid low from the next cycle.
REQ-021 HOLD with out_ready=1 and start=1: -> SHIFT_A directly (back-to-back load), with the counter cleared.
REQ-022 start while in SHIFT_A or SHIFT_B SHALL be ignored; a load is never restarted mid-stream.
REQ-023 The counter width SHALL be clog2(NIBBLE_W)+1 and the counter SHALL never exceed NIBBLE_W-1 at rest; there is no wrap-around beyond the terminal count.
REQ-024 busy SHALL be a registered or pure state decode, with no combinational path from any input to any output.

Reset
REQ-025 rst=1 SHALL force the state to IDLE and clear out_1, out_2, both shift registers, the counter, out_valid and busy to 0 on the next edge.
REQ-026 rst SHALL take priority over every other input in every state, including mid-SHIFT and in HOLD with a pending transfer; a partial load is discarded.

Structure
REQ-027 The state encodings (2-bit) and the default nibble width SHALL reside in the shared bus_breakout definitions include file; bus_breakout and this block SHALL both take NIBBLE_W from it.
REQ-028 A single sub-module, nibble_shift_reg (NIBBLE_W wide, with shift-enable and clear), SHALL be instantiated twice, once for A and once for B; the FSM and counter stay in the top module.

Verification
REQ-029 Reset, then start; serial 0,0,0,1 then 1,0,0,0 with ser_valid=1 every cycle and out_ready=1 -> out_valid is high exactly one cycle after the 8th bit, with out_1=4'b0001 and out_2=4'b1000; the state then returns to IDLE.
REQ-030 Same stream as REQ-029 with ser_valid toggled 1/0 -> the result is identical and out_valid rises 1 cycle after the 8th accepted bit (the 15th stream cycle).
REQ-031 Load 4'b0011 / 4'b1100 with out_ready=0 for 5 cycles -> out_valid stays high and the outputs stay stable; out_ready=1 -> out_valid is low on the next cycle and the outputs still read 0011/1100.
REQ-032 In HOLD with out_ready=1 and start=1 -> the FSM goes directly to SHIFT_A; the next load of 4'b0111 / 4'b1110 completes correctly.
REQ-033 Assert rst after 6 accepted bits -> all outputs read 0 on the next cycle; a following full load of 4'b1111 / 4'b1111 is correct with no residue from the aborted load.
REQ-034 Pulse start during SHIFT_B -> no effect; the pair completes and the counter never exceeds 3.
